// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, access
// sizes, FSM state type and lane widths.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size is funct3[1:0]; 2'b11 never survives the legality check.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    RMW_RD,
    RMW_WR
  } state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline-side request/response and data_memory signals of
// the load/store unit.
//   slave  : the load_store_unit view (takes requests, drives memory)
//   master : the pipeline + data_memory view
interface load_store_unit_if;
  // pipeline side
  logic        req_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        err;
  // data_memory side
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, MemRead, MemWrite, funct3, addr, store_data, mem_rdata,
    output load_data, stall, err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, MemRead, MemWrite, funct3, addr, store_data, mem_rdata,
    input  load_data, stall, err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   ld_word/ld_off/ld_size/ld_unsigned -> ld_data : lane extract + extend
//   st_word/st_data/st_off/st_size     -> st_merged: lane replace in word
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  size_t       ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data,
  input  logic [31:0] st_word,
  input  logic [15:0] st_data,
  input  logic [1:0]  st_off,
  input  size_t       st_size,
  output logic [31:0] st_merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = '0;
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_size)
      SZ_B:    ld_data = {{(WORD_W - BYTE_W){ld_byte[7] & ~ld_unsigned}}, ld_byte};
      SZ_H:    ld_data = {{(WORD_W - HALF_W){ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_word;
    case (st_size)
      SZ_B: begin
        case (st_off)
          2'd0:    st_merged[7:0]   = st_data[7:0];
          2'd1:    st_merged[15:8]  = st_data[7:0];
          2'd2:    st_merged[23:16] = st_data[7:0];
          default: st_merged[31:24] = st_data[7:0];
        endcase
      end
      SZ_H: begin
        if (st_off[1]) st_merged[31:16] = st_data;
        else           st_merged[15:0]  = st_data;
      end
      default: st_merged = st_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-only data_memory.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipeline request/response and data_memory signals
// Loads and sw complete in the request cycle; sb/sh run a read-modify-write
// (IDLE -> RMW_RD -> RMW_WR) with stall high during IDLE and RMW_RD.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit          MISALIGN_TRAP = 1'b1,
  parameter int unsigned MEM_AW        = 10   // 3..31
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  state_t      state, state_nxt;
  logic [31:0] lat_addr;
  logic [15:0] lat_data;
  size_t       lat_size;
  logic [31:0] old_word;
  logic        latch_req;

  size_t       req_size;
  logic        is_store, is_load;
  logic        ld_legal, st_legal, misaligned;
  logic [31:0] ld_data, st_merged;

  // Bits above MEM_AW are forwarded untouched; only the byte offset is cleared.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:MEM_AW], a[MEM_AW-1:2], 2'b00};
  endfunction

  assign req_size = size_t'(bus.funct3[1:0]);
  // MemWrite has priority when both request strobes are set.
  assign is_store = bus.req_valid & bus.MemWrite;
  assign is_load  = bus.req_valid & bus.MemRead & ~bus.MemWrite;
  assign ld_legal = bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign st_legal = bus.funct3 inside {F3_B, F3_H, F3_W};
  assign misaligned = MISALIGN_TRAP &&
                      (((req_size == SZ_H) && bus.addr[0]) ||
                       ((req_size == SZ_W) && (bus.addr[1:0] != 2'b00)));

  lsu_align u_align (
    .ld_word     (bus.mem_rdata),
    .ld_off      (bus.addr[1:0]),
    .ld_size     (req_size),
    .ld_unsigned (bus.funct3[2]),
    .ld_data     (ld_data),
    .st_word     (old_word),
    .st_data     (lat_data),
    .st_off      (lat_addr[1:0]),
    .st_size     (lat_size),
    .st_merged   (st_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      lat_size <= SZ_B;
      old_word <= '0;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        lat_addr <= bus.addr;
        lat_data <= bus.store_data[15:0];
        lat_size <= req_size;
      end
      if (state == RMW_RD) old_word <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    latch_req     = 1'b0;
    bus.stall     = 1'b0;
    bus.err       = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.load_data = '0;

    case (state)
      IDLE: begin
        if (is_store) begin
          if (!st_legal || misaligned) begin
            bus.err = 1'b1;
          end else if (req_size == SZ_W) begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = word_addr(bus.addr);
            bus.mem_wdata = bus.store_data;
          end else begin
            bus.stall = 1'b1;
            latch_req = 1'b1;
            state_nxt = RMW_RD;
          end
        end else if (is_load) begin
          if (!ld_legal || misaligned) begin
            bus.err = 1'b1;
          end else begin
            bus.mem_read  = 1'b1;
            bus.mem_addr  = word_addr(bus.addr);
            bus.load_data = ld_data;
          end
        end
      end
      RMW_RD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = word_addr(lat_addr);
        bus.stall    = 1'b1;
        state_nxt    = RMW_WR;
      end
      RMW_WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = word_addr(lat_addr);
        bus.mem_wdata = st_merged;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are forced low while reset is asserted so an in-flight RMW
    // cannot emit a write after reset rises.
    if (reset) begin
      latch_req     = 1'b0;
      bus.stall     = 1'b0;
      bus.err       = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.load_data = '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MISALIGN_TRAP(1'b1), .MEM_AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word-only data memory model: combinational read, write at posedge.
  logic [31:0] mem [0:63];
  logic        poke;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;
  int          wr_count = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (poke) mem[poke_idx] <= poke_val;
    else if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (bus.mem_write) wr_count <= wr_count + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    bus.req_valid  = v;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = d;
    #2;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic poke_word(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke     = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    poke = 1'b0; poke_idx = '0; poke_val = '0;
    bus.req_valid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
    bus.funct3 = F3_W; bus.addr = 32'h10; bus.store_data = 32'h1234;
    #2;
    vectors++;
    if ({bus.stall, bus.err, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: stall/err/rd/wr=%b expected 0000",
               {bus.stall, bus.err, bus.mem_read, bus.mem_write});
    end
    vectors++;
    if ({bus.mem_addr, bus.mem_wdata, bus.load_data} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h ld=%h expected all 0",
               bus.mem_addr, bus.mem_wdata, bus.load_data);
    end
    poke_word(6'd4, 32'h88776655);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [6]  = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
    logic [31:0] ad [6]  = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10};
    logic [31:0] ex [6]  = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8877,
                             32'h00006655, 32'h88776655, 32'h00000055};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, f3[i], ad[i], 32'h0);
      vectors++;
      if (bus.load_data !== ex[i]) begin
        miscompares++;
        $display("FAIL load[%0d]: load_data=%h expected %h", i, bus.load_data, ex[i]);
      end
      vectors++;
      if ({bus.stall, bus.err, bus.mem_read, bus.mem_addr} !== {3'b001, 32'h10}) begin
        miscompares++;
        $display("FAIL load_ctrl[%0d]: stall=%b err=%b rd=%b addr=%h expected 0 0 1 00000010",
                 i, bus.stall, bus.err, bus.mem_read, bus.mem_addr);
      end
    end
    // Read strobe without req_valid: no access, load_data stays 0.
    drive(1'b0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    vectors++;
    if ({bus.mem_read, bus.load_data} !== 33'h0) begin
      miscompares++;
      $display("FAIL load_idle: rd=%b load_data=%h expected 0 0", bus.mem_read, bus.load_data);
    end
  endtask

  task automatic test_sb_rmw();
    int w0;
    w0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, F3_B, 32'h11, 32'h123456AB);
    vectors++;
    if ({bus.stall, bus.mem_write, bus.mem_read} !== 3'b100) begin
      miscompares++;
      $display("FAIL sb_idle: stall/wr/rd=%b expected 100", {bus.stall, bus.mem_write, bus.mem_read});
    end
    step();
    vectors++;
    if ({bus.stall, bus.mem_write, bus.mem_read, bus.mem_addr} !== {3'b101, 32'h10}) begin
      miscompares++;
      $display("FAIL sb_rd: stall/wr/rd=%b addr=%h expected 101 00000010",
               {bus.stall, bus.mem_write, bus.mem_read}, bus.mem_addr);
    end
    step();
    vectors++;
    if ({bus.stall, bus.mem_write, bus.mem_wdata} !== {2'b01, 32'h8877AB55}) begin
      miscompares++;
      $display("FAIL sb_wr: stall=%b wr=%b wdata=%h expected 0 1 8877ab55",
               bus.stall, bus.mem_write, bus.mem_wdata);
    end
    // Back-to-back load right after RMW_WR.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    vectors++;
    if ({bus.stall, bus.load_data} !== {1'b0, 32'h8877AB55}) begin
      miscompares++;
      $display("FAIL sb_readback: stall=%b load_data=%h expected 0 8877ab55",
               bus.stall, bus.load_data);
    end
    vectors++;
    if (wr_count - w0 !== 1) begin
      miscompares++;
      $display("FAIL sb_wr_count: writes=%0d expected 1", wr_count - w0);
    end
  endtask

  task automatic test_sh_sw();
    poke_word(6'd4, 32'h88776655);
    drive(1'b1, 1'b0, 1'b1, F3_H, 32'h12, 32'h0000CAFE);
    step();
    step();
    vectors++;
    if ({bus.mem_write, bus.mem_wdata} !== {1'b1, 32'hCAFE6655}) begin
      miscompares++;
      $display("FAIL sh_wr: wr=%b wdata=%h expected 1 cafe6655", bus.mem_write, bus.mem_wdata);
    end
    drive(1'b1, 1'b0, 1'b1, F3_W, 32'h14, 32'hDEADBEEF);
    vectors++;
    if ({bus.stall, bus.mem_write, bus.mem_addr, bus.mem_wdata} !==
        {2'b01, 32'h14, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL sw: stall=%b wr=%b addr=%h wdata=%h expected 0 1 00000014 deadbeef",
               bus.stall, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h14, 32'h0);
    vectors++;
    if ({bus.stall, bus.load_data} !== {1'b0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL sw_readback: stall=%b load_data=%h expected 0 deadbeef",
               bus.stall, bus.load_data);
    end
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    vectors++;
    if (bus.load_data !== 32'hCAFE6655) begin
      miscompares++;
      $display("FAIL sh_readback: load_data=%h expected cafe6655", bus.load_data);
    end
  endtask

  task automatic test_errors();
    int w0;
    w0 = wr_count;
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h12, 32'h0);
    vectors++;
    if ({bus.err, bus.mem_read, bus.stall, bus.load_data} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL lw_misalign: err=%b rd=%b stall=%b ld=%h expected 1 0 0 0",
               bus.err, bus.mem_read, bus.stall, bus.load_data);
    end
    drive(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: err=%b expected 0", bus.err);
    end
    drive(1'b1, 1'b0, 1'b1, F3_H, 32'h13, 32'h0000BEEF);
    vectors++;
    if ({bus.err, bus.mem_write, bus.mem_read, bus.stall} !== 4'b1000) begin
      miscompares++;
      $display("FAIL sh_misalign: err/wr/rd/stall=%b expected 1000",
               {bus.err, bus.mem_write, bus.mem_read, bus.stall});
    end
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    vectors++;
    if ({bus.err, bus.mem_read, bus.stall} !== 3'b100) begin
      miscompares++;
      $display("FAIL ld_illegal: err/rd/stall=%b expected 100", {bus.err, bus.mem_read, bus.stall});
    end
    drive(1'b1, 1'b0, 1'b1, F3_BU, 32'h10, 32'h0);
    vectors++;
    if ({bus.err, bus.mem_write, bus.stall} !== 3'b100) begin
      miscompares++;
      $display("FAIL st_illegal: err/wr/stall=%b expected 100", {bus.err, bus.mem_write, bus.stall});
    end
    drive(1'b1, 1'b1, 1'b0, F3_HU, 32'h11, 32'h0);
    vectors++;
    if ({bus.err, bus.mem_read} !== 2'b10) begin
      miscompares++;
      $display("FAIL lhu_misalign: err/rd=%b expected 10", {bus.err, bus.mem_read});
    end
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    vectors++;
    if ({bus.stall, bus.load_data} !== {1'b0, 32'hCAFE6655}) begin
      miscompares++;
      $display("FAIL err_mem_kept: stall=%b load_data=%h expected 0 cafe6655",
               bus.stall, bus.load_data);
    end
    vectors++;
    if (wr_count !== w0) begin
      miscompares++;
      $display("FAIL err_no_write: writes=%0d expected 0", wr_count - w0);
    end
  endtask

  task automatic test_reset_rmw();
    int w0;
    poke_word(6'd4, 32'h88776655);
    w0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, F3_B, 32'h10, 32'h000000FF);
    step();
    vectors++;
    if ({bus.stall, bus.mem_read} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_rmw_rd: stall/rd=%b expected 11", {bus.stall, bus.mem_read});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.stall, bus.mem_read, bus.mem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async: stall/rd/wr=%b expected 000",
               {bus.stall, bus.mem_read, bus.mem_write});
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    vectors++;
    if ({bus.stall, bus.load_data} !== {1'b0, 32'h88776655}) begin
      miscompares++;
      $display("FAIL rst_rmw_mem: stall=%b load_data=%h expected 0 88776655",
               bus.stall, bus.load_data);
    end
    vectors++;
    if (wr_count !== w0) begin
      miscompares++;
      $display("FAIL rst_rmw_nowrite: writes=%0d expected 0", wr_count - w0);
    end
  endtask

  task automatic test_both_strobes();
    drive(1'b1, 1'b1, 1'b1, F3_W, 32'h20, 32'h55AA55AA);
    vectors++;
    if ({bus.mem_write, bus.mem_read, bus.stall, bus.load_data} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL both_strobes: wr/rd/stall=%b ld=%h expected 100 0",
               {bus.mem_write, bus.mem_read, bus.stall}, bus.load_data);
    end
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h20, 32'h0);
    vectors++;
    if (bus.load_data !== 32'h55AA55AA) begin
      miscompares++;
      $display("FAIL both_readback: load_data=%h expected 55aa55aa", bus.load_data);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sb_rmw();
    test_sh_sw();
    test_errors();
    test_reset_rmw();
    test_both_strobes();
    drive(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage front end that sits between the EX/MEM pipeline register and the word-only data_memory.
- Decodes funct3 into byte, halfword and word accesses. Sign- or zero-extends load data.
- Checks alignment and raises an error on misaligned or illegal accesses.
- data_memory only writes full 32-bit words, so sub-word stores (sb/sh) run as a read-modify-write (RMW) sequence. The pipeline is stalled for the RMW duration.

Parameters:
- MISALIGN_TRAP, default 1. 1: misaligned access raises err and suppresses the memory access. 0: low address bits are ignored and the access goes to the aligned word/half.
- MEM_AW, default 10. Byte-address bits forwarded to memory; upper address bits pass through unchanged.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  EX/MEM slot holds a valid instruction
- MemRead  in  1  load request
- MemWrite  in  1  store request
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  32  byte address (ALU result)
- store_data  in  32  rs2 value
- load_data  out  32  extended load result, valid the same cycle as the load
- stall  out  1  holds IF/ID/EX/MEM while high
- err  out  1  one-cycle pulse: misaligned access or illegal funct3
- mem_read  out  1  to data_memory MemRead
- mem_write  out  1  to data_memory MemWrite
- mem_addr  out  32  word-aligned address: {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  data_memory read_data (combinational)

Behaviour:
- Reset is asynchronous and active-high. In reset: state=IDLE; all request latches =0. Outputs stall, err, mem_read, mem_write =0; mem_addr, mem_wdata, load_data =0.
- Request is accepted only in IDLE with req_valid & (MemRead|MemWrite). If both MemRead and MemWrite are high, MemWrite wins and the read is ignored.
- Illegal funct3 (loads: 011, 110, 111; stores: anything other than 000/001/010): err=1 for that cycle, no memory access, no stall.
- Alignment check with MISALIGN_TRAP=1:
  - half access requires addr[0]=0;
  - word access requires addr[1:0]=00;
  - on violation: err=1, mem_read=mem_write=0, stall=0.
- Loads: zero added latency, no stall.
  - In IDLE: mem_read=1, mem_addr aligned.
  - Byte lane is selected by addr[1:0]; half lane by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - load_data=0 whenever no load is active.
- sw: single cycle, no stall. In IDLE: mem_write=1, mem_wdata=store_data; memory updates at the next edge.
- sb/sh: FSM IDLE -> RMW_RD -> RMW_WR -> IDLE.
  - IDLE, request present: stall=1 combinationally. At the edge, latch addr, funct3 and store_data; go to RMW_RD.
  - RMW_RD: mem_read=1, mem_addr=latched aligned address, stall=1. At the edge, capture mem_rdata into old_word; go to RMW_WR.
  - RMW_WR: mem_write=1, mem_wdata=old_word with the target lane(s) replaced by store_data[7:0] or [15:0]. stall=0, so the pipeline advances on the same edge as the write. Go to IDLE.
  - Total: 3 cycles, stall high for exactly 2.
- Request inputs are ignored outside IDLE. The pipeline is held, so inputs stay stable anyway.
- Reset asserted in RMW_RD or RMW_WR: sequence abandoned; no mem_write is issued after reset asserts; memory is unchanged.
- Back-to-back: a load or store presented the cycle after RMW_WR is accepted normally in IDLE.
- mem_addr bits above MEM_AW pass through unchanged; data_memory decodes only its own bits.

Decomposition:
- lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state typedef {IDLE, RMW_RD, RMW_WR};
  - lane-width constants.
- One sub-module, lsu_align, purely combinational. It does load lane extraction plus extension, and store lane merge (old_word, data, addr[1:0], size). The top keeps the FSM, latches, alignment check and port muxing.

Test Plan:
- Memory word 0x10 preloaded with 0x88776655:
  - lb @0x13 -> load_data=0xFFFFFF88;
  - lbu @0x13 -> 0x00000088;
  - lh @0x12 -> 0xFFFF8877;
  - lhu @0x10 -> 0x00006655;
  - stall=0 throughout.
- sb @0x11 with store_data=0x123456AB:
  - stall=1 for 2 cycles;
  - mem_write pulses once, in RMW_WR, with mem_wdata=0x8877AB55;
  - follow-up lw @0x10 -> 0x8877AB55.
- sh @0x12 with store_data=0xCAFE -> word becomes 0xCAFE6655; sw @0x14 with 0xDEADBEEF -> 1 cycle, stall=0, readback OK.
- Misaligned and illegal accesses, with MISALIGN_TRAP=1:
  - lw @0x12 -> err pulse, mem_read=0;
  - sh @0x13 -> err, no stall, memory unchanged;
  - load funct3=011 -> err.
- Reset asserted during RMW_RD of sb @0x10 -> state IDLE, stall=0, no mem_write ever seen, word still 0x88776655.
- MemRead & MemWrite both high with sw @0x20 (0x55AA55AA) -> write performed, load_data=0.
